// File: rtl/sdram_image_writer.sv
// Write side of the video SDRAM image store: buffers loader words in a small FIFO
// and issues single-word SDRAM writes at sequential addresses from a base.
module sdram_image_writer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int COUNT_WIDTH = 20
) (
    input  logic                   clk_sys_99_287,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [24:0]            base_addr,
    input  logic                   in_wr,
    input  logic [15:0]            in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic                   overflow,
    output logic                   sd_wr,
    output logic [24:0]            sd_wr_addr,
    output logic [15:0]            sd_wr_data,
    input  logic                   sd_wr_ack
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [16:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic [16:0] head;
    logic        armed;
    logic [24:0] next_addr;
    logic        cur_last;
    logic        push, pop, ack_fire;
    logic [AW-1:0] wr_idx;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    assign in_ready = armed & ~fifo_full;
    // A start flushes the FIFO, so a word arriving with it always fits as the first entry.
    assign push     = in_wr & (start | in_ready);
    assign wr_idx   = start ? '0 : wr_ptr[AW-1:0];
    assign ack_fire = (state_q == WRITE) & sd_wr_ack;

    assign sd_wr = (state_q == WRITE);
    assign done  = (state_q == DONE);
    assign busy  = armed | ~fifo_empty | (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (start) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (sd_wr_ack) begin
                        if (cur_last) begin
                            state_d = DONE;
                        end else if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys_99_287 or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_sys_99_287) begin
        if (push) fifo_mem[wr_idx] <= {in_last, in_data};
    end

    always_ff @(posedge clk_sys_99_287 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (start) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PTR_ONE : '0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_sys_99_287 or negedge reset_n) begin
        if (!reset_n) begin
            armed      <= 1'b0;
            overflow   <= 1'b0;
            next_addr  <= '0;
            word_count <= '0;
        end else if (start) begin
            armed      <= ~(in_wr & in_last);
            overflow   <= 1'b0;
            next_addr  <= base_addr;
            word_count <= '0;
        end else begin
            if (push && in_last)              armed    <= 1'b0;
            if (in_wr && armed && fifo_full)  overflow <= 1'b1;
            if (ack_fire) begin
                next_addr  <= next_addr + 25'd1;
                word_count <= word_count + COUNT_WIDTH'(1);
            end
        end
    end

    // The address of a word popped on an ack edge is the one after the word being acked.
    always_ff @(posedge clk_sys_99_287 or negedge reset_n) begin
        if (!reset_n) begin
            sd_wr_addr <= '0;
            sd_wr_data <= '0;
            cur_last   <= 1'b0;
        end else if (pop) begin
            sd_wr_addr <= ack_fire ? next_addr + 25'd1 : next_addr;
            sd_wr_data <= head[15:0];
            cur_last   <= head[16];
        end
    end
endmodule

// File: tb/tb_sdram_image_writer.sv
// Randomised and directed bench for sdram_image_writer against a queue-based transfer model.
module tb_sdram_image_writer;
    localparam int DEPTH = 16;
    localparam int CW    = 20;

    logic          clk, reset_n, start, in_wr, in_last, sd_wr_ack;
    logic [24:0]   base_addr;
    logic [15:0]   in_data;
    logic          in_ready, busy, done, overflow, sd_wr;
    logic [CW-1:0] word_count;
    logic [24:0]   sd_wr_addr;
    logic [15:0]   sd_wr_data;

    sdram_image_writer #(.FIFO_DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .clk_sys_99_287(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .in_wr(in_wr), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .busy(busy), .done(done), .word_count(word_count), .overflow(overflow),
        .sd_wr(sd_wr), .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_ack(sd_wr_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Transfer-level model: a queue of pending words plus the word in flight.
    logic [16:0]   q[$];
    logic          m_armed, m_wr, m_cur_last, m_done, m_ovf;
    logic [24:0]   m_cur_addr, m_next;
    logic [15:0]   m_cur_data;
    logic [CW-1:0] m_cnt;

    task automatic model_reset();
        q.delete();
        m_armed = 0; m_wr = 0; m_cur_last = 0; m_done = 0; m_ovf = 0;
        m_cur_addr = 0; m_next = 0; m_cur_data = 0; m_cnt = 0;
    endtask

    task automatic model_load();
        logic [16:0] w;
        w = q.pop_front();
        m_cur_last = w[16];
        m_cur_data = w[15:0];
        m_cur_addr = m_next;
        m_wr = 1;
    endtask

    task automatic model_update();
        bit full, acc;
        int pre;
        if (!reset_n) begin
            model_reset();
        end else if (start) begin
            q.delete();
            m_armed = 1; m_next = base_addr; m_cnt = 0; m_ovf = 0; m_wr = 0; m_done = 0;
            if (in_wr) begin
                q.push_back({in_last, in_data});
                if (in_last) m_armed = 0;
            end
        end else begin
            full = (q.size() == DEPTH);
            acc  = in_wr && m_armed && !full;
            if (in_wr && m_armed && full) m_ovf = 1;
            pre = q.size();
            if (m_done) begin
                m_done = 0;
            end else if (m_wr) begin
                if (sd_wr_ack) begin
                    m_next = m_next + 25'd1;
                    m_cnt  = m_cnt + 1'b1;
                    if (m_cur_last) begin
                        m_wr = 0;
                        m_done = 1;
                    end else if (pre > 0) model_load();
                    else m_wr = 0;
                end
            end else if (pre > 0) begin
                model_load();
            end
            if (acc) begin
                q.push_back({in_last, in_data});
                if (in_last) m_armed = 0;
            end
        end
    endtask

    task automatic compare();
        chk("sd_wr", sd_wr, m_wr);
        chk("busy", busy, m_armed || q.size() > 0 || m_wr || m_done);
        chk("in_ready", in_ready, m_armed && q.size() < DEPTH);
        chk("done", done, m_done);
        chk("word_count", word_count, m_cnt);
        chk("overflow", overflow, m_ovf);
        if (m_wr) begin
            chk("sd_wr_addr", sd_wr_addr, m_cur_addr);
            chk("sd_wr_data", sd_wr_data, m_cur_data);
        end
    endtask

    typedef struct { logic [24:0] a; logic [15:0] d; } wr_t;
    wr_t wlog[$];
    int  done_seen;
    int  ack_mode;  // 0: tied high, 1: held low, 2: random

    task automatic apply_ack();
        case (ack_mode)
            0:       sd_wr_ack = 1'b1;
            1:       sd_wr_ack = 1'b0;
            default: sd_wr_ack = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic set_ack(input int mode);
        ack_mode = mode;
        apply_ack();
    endtask

    task automatic step();
        if (reset_n && sd_wr && sd_wr_ack) wlog.push_back('{sd_wr_addr, sd_wr_data});
        @(posedge clk);
        model_update();
        #1;
        compare();
        if (done) done_seen++;
        apply_ack();
    endtask

    task automatic do_start(input logic [24:0] b);
        start = 1; base_addr = b;
        step();
        start = 0;
    endtask

    // Sends word indices i0..i1-1 of a transfer of 'total' words, waiting on in_ready.
    task automatic send_range(input int i0, input int i1, input int total, input logic [15:0] d0);
        int i, guard;
        i = i0; guard = 0;
        while (i < i1 && guard < 2000) begin
            if (in_ready) begin
                in_wr = 1; in_data = d0 + 16'(i); in_last = (i == total - 1);
                i++;
            end
            step();
            in_wr = 0; in_last = 0;
            guard++;
        end
        chk("send_timeout", 32'(i), 32'(i1));
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    int acc, hits;

    initial begin
        reset_n = 0; start = 0; base_addr = 0; in_wr = 0; in_data = 0; in_last = 0;
        sd_wr_ack = 0; ack_mode = 1; done_seen = 0;
        model_reset();
        #1;
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);
        step(); step();
        reset_n = 1;
        step(); step();
        chk("post_rst_in_ready", in_ready, 0);

        // Basic 4-word transfer, ack tied high.
        set_ack(0); wlog.delete(); done_seen = 0;
        do_start(25'h0001000);
        send_range(0, 4, 4, 16'hA000);
        wait_idle(50);
        chk("t2_len", 32'(wlog.size()), 4);
        for (int i = 0; i < wlog.size(); i++) begin
            chk("t2_addr", wlog[i].a, 32'h1000 + 32'(i));
            chk("t2_data", wlog[i].d, 32'hA000 + 32'(i));
        end
        chk("t2_done_cycles", 32'(done_seen), 1);
        chk("t2_word_count", word_count, 4);

        // Ack stall: 20 words, one in flight plus a full FIFO before in_ready drops.
        set_ack(1); wlog.delete(); done_seen = 0;
        do_start(25'h0002000);
        acc = 0;
        while (in_ready && acc < 20) begin
            in_wr = 1; in_data = 16'h3000 + 16'(acc); in_last = (acc == 19);
            acc++;
            step();
            in_wr = 0; in_last = 0;
        end
        chk("t3_accepted", 32'(acc), DEPTH + 1);
        chk("t3_in_ready", in_ready, 0);
        step(); step();
        chk("t3_addr_held", sd_wr_addr, 32'h2000);
        set_ack(0);
        send_range(17, 20, 20, 16'h3000);
        wait_idle(100);
        chk("t3_len", 32'(wlog.size()), 20);
        for (int i = 0; i < wlog.size(); i++) chk("t3_data", wlog[i].d, 32'h3000 + 32'(i));
        chk("t3_overflow", overflow, 0);

        // Overflow: write while full, sticky, dropped word never written, cleared by start.
        set_ack(1); wlog.delete();
        do_start(25'h0003000);
        acc = 0;
        while (in_ready && acc < 20) begin
            in_wr = 1; in_data = 16'h4000 + 16'(acc); in_last = 0;
            acc++;
            step();
            in_wr = 0;
        end
        in_wr = 1; in_data = 16'hDEAD; in_last = 0;
        step();
        in_wr = 0;
        chk("t4_overflow_set", overflow, 1);
        step(); step(); step();
        chk("t4_overflow_sticky", overflow, 1);
        set_ack(0);
        send_range(17, 20, 20, 16'h4000);
        wait_idle(100);
        chk("t4_overflow_after", overflow, 1);
        chk("t4_len", 32'(wlog.size()), 20);
        hits = 0;
        foreach (wlog[i]) if (wlog[i].d == 16'hDEAD) hits++;
        chk("t4_dropped_word", 32'(hits), 0);
        do_start(25'h0);
        chk("t4_overflow_clear", overflow, 0);

        // Address wrap.
        wlog.delete();
        do_start(25'h1FFFFFE);
        send_range(0, 3, 3, 16'h5000);
        wait_idle(50);
        chk("t5_len", 32'(wlog.size()), 3);
        if (wlog.size() == 3) begin
            chk("t5_addr0", wlog[0].a, 32'h1FFFFFE);
            chk("t5_addr1", wlog[1].a, 32'h1FFFFFF);
            chk("t5_addr2", wlog[2].a, 32'h0000000);
        end

        // Abort mid-transfer with 5 words queued behind the one in flight.
        set_ack(1);
        do_start(25'h0005000);
        send_range(0, 6, 10, 16'h6000);
        chk("t6_sd_wr_before", sd_wr, 1);
        wlog.delete(); done_seen = 0;
        do_start(25'h0000100);
        chk("t6_sd_wr_abort", sd_wr, 0);
        chk("t6_count_restart", word_count, 0);
        set_ack(0);
        send_range(0, 2, 2, 16'h7000);
        wait_idle(50);
        chk("t6_len", 32'(wlog.size()), 2);
        if (wlog.size() == 2) begin
            chk("t6_addr0", wlog[0].a, 32'h100);
            chk("t6_addr1", wlog[1].a, 32'h101);
            chk("t6_data0", wlog[0].d, 32'h7000);
        end
        chk("t6_word_count", word_count, 2);
        chk("t6_done_cycles", 32'(done_seen), 1);

        // Asynchronous reset mid-WRITE.
        set_ack(1);
        do_start(25'h0006000);
        send_range(0, 3, 10, 16'h8000);
        step();
        chk("t1_sd_wr_before", sd_wr, 1);
        #3 reset_n = 0;
        #1;
        chk("t1_async_sd_wr", sd_wr, 0);
        chk("t1_async_busy", busy, 0);
        chk("t1_async_in_ready", in_ready, 0);
        chk("t1_async_word_count", word_count, 0);
        step(); step();
        reset_n = 1;
        step(); step();
        chk("t1_in_ready_idle", in_ready, 0);

        // Randomised transfers with random ack, gaps, writes while not ready, and aborts.
        for (int t = 0; t < 40; t++) begin
            logic [24:0] b;
            int n, stop, sent, guard;
            b = 25'($urandom);
            if ($urandom_range(0, 3) == 0) b = 25'h1FFFFFF - 25'($urandom_range(0, 3));
            set_ack($urandom_range(0, 2) == 0 ? 0 : 2);
            n = $urandom_range(1, 30);
            stop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : n;
            start = 1; base_addr = b;
            sent = 0;
            if ($urandom_range(0, 7) == 0 && n > 1) begin
                in_wr = 1; in_data = 16'($urandom); in_last = 0;
                sent = 1;
            end
            step();
            start = 0; in_wr = 0;
            guard = 0;
            while (sent < stop && guard < 3000) begin
                if (in_ready && $urandom_range(0, 3) != 0) begin
                    in_wr = 1; in_data = 16'($urandom); in_last = (sent == n - 1);
                    sent++;
                end else if (!in_ready && $urandom_range(0, 3) == 0) begin
                    in_wr = 1; in_data = 16'($urandom); in_last = 0;
                end
                step();
                in_wr = 0; in_last = 0;
                guard++;
            end
            chk("rand_send_timeout", 32'(sent), 32'(stop));
            if (stop == n) wait_idle(500);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
